// File: rtl/alu_ctl_seq_unit.sv
// alu_ctl_seq_unit: registered EX-stage ALU with integrated ALUOp/FuncCode
// decode, valid/ready input handshake and a multi-cycle shift-add MULTU
// that writes HI/LO.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operation request / block can accept this cycle
//   ALUOp, FuncCode     main-control opcode and R-type funct field
//   A, B                operands (WIDTH bits)
//   out_valid           one-cycle pulse: Result/Zero/ALUctl/err valid
//   Result, Zero        registered result and Result==0 flag
//   ALUctl, err         decoded control code of completed op, illegal flag
//   HI, LO              product registers (written only by MULTU)
//   busy                multiply in progress
module alu_ctl_seq_unit #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       FuncCode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic [3:0]       ALUctl,
  output logic             err,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] C_AND = 4'b0000, C_OR  = 4'b0001, C_ADD = 4'b0010,
                         C_SUB = 4'b0110, C_SLT = 4'b0111, C_MUL = 4'b1000,
                         C_NOR = 4'b1100, C_ILL = 4'b1111;

  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_nx;

  logic [3:0]         dec_ctl;
  logic [WIDTH-1:0]   dec_res;
  logic               dec_mul;
  logic [WIDTH-1:0]   mcand, mplier;
  logic [2*WIDTH-1:0] acc, acc_nx;
  logic [WIDTH:0]     psum;
  logic [CW-1:0]      cnt;

  // Decode
  always_comb begin
    dec_ctl = C_ILL;
    unique case (ALUOp)
      2'b00: dec_ctl = C_ADD;
      2'b01: dec_ctl = C_SUB;
      2'b10: begin
        case (FuncCode)
          6'b100000: dec_ctl = C_ADD;
          6'b100010: dec_ctl = C_SUB;
          6'b100100: dec_ctl = C_AND;
          6'b100101: dec_ctl = C_OR;
          6'b100111: dec_ctl = C_NOR;
          6'b101010: dec_ctl = C_SLT;
          6'b011001: dec_ctl = MUL_EN ? C_MUL : C_ILL;
          default:   dec_ctl = C_ILL;
        endcase
      end
      default: dec_ctl = C_ILL;
    endcase
    dec_mul = (dec_ctl == C_MUL);
  end

  // Single-cycle datapath; illegal (and multu, unused here) yield 0
  always_comb begin
    dec_res = '0;
    case (dec_ctl)
      C_ADD:   dec_res = A + B;
      C_SUB:   dec_res = A - B;
      C_AND:   dec_res = A & B;
      C_OR:    dec_res = A | B;
      C_NOR:   dec_res = ~(A | B);
      C_SLT:   dec_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: dec_res = '0;
    endcase
  end

  // Shift-add step: add multiplicand into the upper half (keeping the carry),
  // then shift the whole accumulator right by one. After WIDTH steps the
  // accumulator holds the full product.
  always_comb begin
    psum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
    acc_nx = {psum, acc[WIDTH-1:1]};
  end

  // FSM
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && dec_mul) state_nx = MUL;
      end
      MUL: begin
        busy = 1'b1;
        if (cnt == '0) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      Result    <= '0;
      Zero      <= 1'b0;
      ALUctl    <= 4'b0000;
      err       <= 1'b0;
      HI        <= '0;
      LO        <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      out_valid <= 1'b0;
      if (state == IDLE) begin
        if (in_valid) begin
          if (dec_mul) begin
            mcand  <= A;
            mplier <= B;
            acc    <= '0;
            cnt    <= CW'(WIDTH-1);
          end else begin
            Result    <= dec_res;
            Zero      <= (dec_res == '0);
            ALUctl    <= dec_ctl;
            err       <= (dec_ctl == C_ILL);
            out_valid <= 1'b1;
          end
        end
      end else begin
        acc    <= acc_nx;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
        if (cnt == '0) begin
          HI        <= acc_nx[2*WIDTH-1:WIDTH];
          LO        <= acc_nx[WIDTH-1:0];
          Result    <= acc_nx[WIDTH-1:0];
          Zero      <= (acc_nx[WIDTH-1:0] == '0);
          ALUctl    <= C_MUL;
          err       <= 1'b0;
          out_valid <= 1'b1;
        end
      end
    end
  end
endmodule
